// File: rtl/apb_irq_fetch_master.sv
// APB initiator for the interrupt/event controller core port.
// Fetches the one-hot ACK register when irq_i is high, converts it to a
// 5-bit ID handed to the core over valid/ready, and forwards core writes
// to the ENABLE and PENDING registers.
module apb_irq_fetch_master #(
    parameter int                        APB_ADDR_WIDTH = 12,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        TIMEOUT        = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR,
    input  logic                      irq_i,
    output logic [4:0]                id_o,
    output logic                      id_valid_o,
    input  logic                      id_ready_i,
    input  logic                      wr_req_i,
    input  logic                      wr_sel_i,
    input  logic [31:0]               wr_data_i,
    output logic                      wr_done_o,
    output logic                      err_o
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_ENABLE  = BASE_ADDR;
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_PENDING = BASE_ADDR + APB_ADDR_WIDTH'(4);
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_ACK     = BASE_ADDR + APB_ADDR_WIDTH'(8);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        DELIVER = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [APB_ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [31:0]                 pwdata_q, pwdata_d;
    logic                        pwrite_q, pwrite_d;
    logic                        psel_q, psel_d;
    logic                        penable_q, penable_d;
    logic [4:0]                  id_q, id_d;
    logic                        id_valid_q, id_valid_d;
    logic                        wr_done_q, wr_done_d;
    logic                        err_q, err_d;

    // Index of the highest set bit; later (higher) bits overwrite earlier ones.
    function automatic logic [4:0] msb_index(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    // Next-state and next-output computation for the transfer FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pwrite_d   = pwrite_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        id_d       = id_q;
        id_valid_d = id_valid_q;
        wr_done_d  = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // wr_done_q masks the request the core is still holding
                // in the cycle it sees its completion pulse.
                if (wr_req_i && !wr_done_q) begin
                    paddr_d   = wr_sel_i ? ADDR_PENDING : ADDR_ENABLE;
                    pwdata_d  = wr_data_i;
                    pwrite_d  = 1'b1;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end else if (irq_i) begin
                    paddr_d   = ADDR_ACK;
                    pwrite_d  = 1'b0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                    if (PSLVERR) begin
                        err_d     = 1'b1;
                        wr_done_d = pwrite_q;
                    end else if (pwrite_q) begin
                        wr_done_d = 1'b1;
                    end else if (PRDATA != 32'd0) begin
                        id_d       = msb_index(PRDATA);
                        id_valid_d = 1'b1;
                        state_d    = DELIVER;
                    end
                    // A zero ACK read is a stale irq_i: dropped silently.
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th wait cycle: abandon the transfer.
                    err_d     = 1'b1;
                    wr_done_d = pwrite_q;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DELIVER: begin
                // No bus activity here so only one ACK read is ever in flight.
                if (id_ready_i) begin
                    id_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pwrite_q   <= 1'b0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            id_q       <= '0;
            id_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            pwrite_q   <= pwrite_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            id_q       <= id_d;
            id_valid_q <= id_valid_d;
            wr_done_q  <= wr_done_d;
            err_q      <= err_d;
        end
    end

    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;
    assign PWRITE     = pwrite_q;
    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;
    assign id_o       = id_q;
    assign id_valid_o = id_valid_q;
    assign wr_done_o  = wr_done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_apb_irq_fetch_master.sv
// Directed bench for apb_irq_fetch_master with a small APB slave model
// and scoreboards for delivered IDs and completed bus transfers.
module tb_apb_irq_fetch_master;

    localparam int AW = 12;

    logic          HCLK;
    logic          HRESET;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic          irq_i;
    logic [4:0]    id_o;
    logic          id_valid_o;
    logic          id_ready_i;
    logic          wr_req_i;
    logic          wr_sel_i;
    logic [31:0]   wr_data_i;
    logic          wr_done_o;
    logic          err_o;

    apb_irq_fetch_master #(
        .APB_ADDR_WIDTH (AW),
        .BASE_ADDR      (12'h000),
        .TIMEOUT        (4)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PWRITE     (PWRITE),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
        .irq_i      (irq_i),
        .id_o       (id_o),
        .id_valid_o (id_valid_o),
        .id_ready_i (id_ready_i),
        .wr_req_i   (wr_req_i),
        .wr_sel_i   (wr_sel_i),
        .wr_data_i  (wr_data_i),
        .wr_done_o  (wr_done_o),
        .err_o      (err_o)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [31:0]   data;
    } xfer_t;

    xfer_t      exp_bus[$];
    xfer_t      got_bus[$];
    logic [4:0] exp_id[$];

    int vectors     = 0;
    int miscompares = 0;

    // Slave configuration
    int          cfg_wait   = 0;
    bit          cfg_stall  = 0;
    bit          cfg_err    = 0;
    logic [31:0] cfg_prdata = 32'h0;
    int          acc_cnt    = 0;

    initial begin
        PREADY  = 1'b0;
        PRDATA  = 32'h0;
        PSLVERR = 1'b0;
    end

    // APB slave: PREADY rises after cfg_wait ACCESS cycles unless stalled.
    always @(posedge HCLK) begin
        #1;
        if (PSEL && PENABLE) acc_cnt = acc_cnt + 1;
        else                 acc_cnt = 0;
        PREADY  = !cfg_stall && (acc_cnt > cfg_wait);
        PRDATA  = cfg_prdata;
        PSLVERR = cfg_err;
    end

    // Bus monitor: record every completed transfer.
    always @(negedge HCLK) begin
        xfer_t x;
        if (PSEL && PENABLE && PREADY) begin
            x.addr = PADDR;
            x.wr   = PWRITE;
            x.data = PWDATA;
            got_bus.push_back(x);
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
        $display("check %-14s got 0x%0h want 0x%0h", tag, obs, exp);
    endtask

    task automatic push_bus(input logic [AW-1:0] a, input logic w, input logic [31:0] d);
        xfer_t x;
        x.addr = a;
        x.wr   = w;
        x.data = d;
        exp_bus.push_back(x);
    endtask

    // Compare every recorded transfer against the expected list, then clear.
    task automatic check_bus(input string tag);
        xfer_t e, g;
        chk({tag, "_cnt"}, 64'(got_bus.size()), 64'(exp_bus.size()));
        while (exp_bus.size() > 0 && got_bus.size() > 0) begin
            e = exp_bus.pop_front();
            g = got_bus.pop_front();
            chk({tag, "_addr"}, 64'(g.addr), 64'(e.addr));
            chk({tag, "_wr"}, 64'(g.wr), 64'(e.wr));
            if (e.wr) chk({tag, "_data"}, 64'(g.data), 64'(e.data));
        end
        exp_bus.delete();
        got_bus.delete();
    endtask

    // Advance until an output event appears; cyc = cycles after the start edge, 0 if none.
    task automatic await_evt(input int budget, input bit drop_irq, output int cyc);
        cyc = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (drop_irq && i == 1) irq_i = 1'b0;
            if (id_valid_o || err_o || wr_done_o) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        logic [4:0] eid;

        HRESET     = 1'b1;
        irq_i      = 1'b0;
        id_ready_i = 1'b0;
        wr_req_i   = 1'b0;
        wr_sel_i   = 1'b0;
        wr_data_i  = 32'h0;
        tick();
        tick();

        // Reset values
        chk("rst_psel", 64'(PSEL), 64'(0));
        chk("rst_penable", 64'(PENABLE), 64'(0));
        chk("rst_pwrite", 64'(PWRITE), 64'(0));
        chk("rst_paddr", 64'(PADDR), 64'(0));
        chk("rst_pwdata", 64'(PWDATA), 64'(0));
        chk("rst_id", 64'(id_o), 64'(0));
        chk("rst_outs", 64'({id_valid_o, wr_done_o, err_o}), 64'(0));
        HRESET = 1'b0;
        tick();

        // id_ready while idle has no effect
        id_ready_i = 1'b1;
        tick();
        chk("idle_rdy", 64'({id_valid_o, PSEL}), 64'(0));
        id_ready_i = 1'b0;

        // Read path with backpressure and a write queued behind DELIVER
        cfg_prdata = 32'h0000_0400;
        exp_id.push_back(5'd10);
        push_bus(12'h008, 1'b0, 32'h0);
        irq_i = 1'b1;
        tick();
        irq_i = 1'b0;
        chk("rd_setup", 64'({PSEL, PENABLE}), 64'(2'b10));
        chk("rd_paddr", 64'(PADDR), 64'(12'h008));
        chk("rd_pwrite", 64'(PWRITE), 64'(0));
        tick();
        chk("rd_access", 64'({PSEL, PENABLE}), 64'(2'b11));
        tick();
        eid = exp_id.pop_front();
        chk("rd_valid", 64'(id_valid_o), 64'(1));
        chk("rd_id", 64'(id_o), 64'(eid));
        wr_req_i  = 1'b1;
        wr_sel_i  = 1'b0;
        wr_data_i = 32'h0000_1234;
        push_bus(12'h000, 1'b1, 32'h0000_1234);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_id", 64'({id_valid_o, id_o}), 64'({1'b1, eid}));
            chk("bp_bus", 64'({PSEL, PENABLE}), 64'(0));
        end
        id_ready_i = 1'b1;
        tick();
        id_ready_i = 1'b0;
        chk("hs_valid", 64'(id_valid_o), 64'(0));
        chk("hs_psel", 64'(PSEL), 64'(0));
        tick();
        chk("b2b_setup", 64'({PSEL, PENABLE, PWRITE}), 64'(3'b101));
        chk("b2b_paddr", 64'(PADDR), 64'(12'h000));
        await_evt(6, 1'b0, cyc);
        chk("b2b_done_cyc", 64'(cyc), 64'(2));
        chk("b2b_done", 64'({wr_done_o, err_o}), 64'(2'b10));
        wr_req_i = 1'b0;
        tick();
        check_bus("bus_rd_b2b");

        // Spurious zero read
        cfg_prdata = 32'h0;
        push_bus(12'h008, 1'b0, 32'h0);
        irq_i = 1'b1;
        await_evt(8, 1'b1, cyc);
        chk("spur_none", 64'(cyc), 64'(0));
        chk("spur_idle", 64'({PSEL, PENABLE, id_valid_o}), 64'(0));
        check_bus("bus_spur");

        // Write priority, then ACK read with multi-bit data
        cfg_prdata = 32'h8000_0001;
        wr_req_i   = 1'b1;
        wr_sel_i   = 1'b1;
        wr_data_i  = 32'h0000_00A5;
        irq_i      = 1'b1;
        push_bus(12'h004, 1'b1, 32'h0000_00A5);
        push_bus(12'h008, 1'b0, 32'h0);
        exp_id.push_back(5'd31);
        await_evt(8, 1'b0, cyc);
        wr_req_i = 1'b0;
        chk("wp_done_cyc", 64'(cyc), 64'(3));
        chk("wp_done", 64'({wr_done_o, err_o, id_valid_o}), 64'(3'b100));
        chk("wp_paddr", 64'(PADDR), 64'(12'h004));
        chk("wp_pwdata", 64'(PWDATA), 64'(32'hA5));
        tick();
        irq_i = 1'b0;
        chk("wp_rd_setup", 64'({PSEL, PWRITE}), 64'(2'b10));
        chk("wp_rd_paddr", 64'(PADDR), 64'(12'h008));
        await_evt(8, 1'b0, cyc);
        chk("mb_cyc", 64'(cyc), 64'(2));
        chk("mb_id", 64'({id_valid_o, id_o}), 64'({1'b1, exp_id.pop_front()}));
        id_ready_i = 1'b1;
        tick();
        id_ready_i = 1'b0;
        chk("mb_hs", 64'(id_valid_o), 64'(0));
        check_bus("bus_wp");

        // Three wait states
        cfg_prdata = 32'h0000_0020;
        cfg_wait   = 3;
        exp_id.push_back(5'd5);
        push_bus(12'h008, 1'b0, 32'h0);
        irq_i = 1'b1;
        await_evt(12, 1'b1, cyc);
        chk("ws_cyc", 64'(cyc), 64'(6));
        chk("ws_id", 64'({id_valid_o, err_o, id_o}), 64'({2'b10, exp_id.pop_front()}));
        id_ready_i = 1'b1;
        tick();
        id_ready_i = 1'b0;
        cfg_wait = 0;
        check_bus("bus_ws");

        // Slave error on a read
        cfg_prdata = 32'h0000_0100;
        cfg_err    = 1'b1;
        push_bus(12'h008, 1'b0, 32'h0);
        irq_i = 1'b1;
        await_evt(8, 1'b1, cyc);
        chk("se_cyc", 64'(cyc), 64'(3));
        chk("se_flags", 64'({err_o, id_valid_o, wr_done_o}), 64'(3'b100));
        cfg_err = 1'b0;
        tick();
        chk("se_after", 64'({err_o, id_valid_o, PSEL}), 64'(0));
        check_bus("bus_se");

        // Timeout with PREADY stuck low
        cfg_stall = 1'b1;
        irq_i     = 1'b1;
        await_evt(12, 1'b1, cyc);
        chk("to_cyc", 64'(cyc), 64'(6));
        chk("to_flags", 64'({err_o, id_valid_o, wr_done_o}), 64'(3'b100));
        chk("to_bus", 64'({PSEL, PENABLE}), 64'(0));
        tick();
        chk("to_pulse", 64'(err_o), 64'(0));
        cfg_stall = 1'b0;
        check_bus("bus_to");

        // Reset in the middle of ACCESS
        cfg_stall = 1'b1;
        irq_i     = 1'b1;
        tick();
        irq_i = 1'b0;
        tick();
        chk("mr_access", 64'({PSEL, PENABLE}), 64'(2'b11));
        HRESET = 1'b1;
        tick();
        HRESET    = 1'b0;
        cfg_stall = 1'b0;
        chk("mr_bus", 64'({PSEL, PENABLE, PWRITE}), 64'(0));
        chk("mr_addr", 64'(PADDR), 64'(0));
        chk("mr_outs", 64'({id_valid_o, id_o, wr_done_o, err_o}), 64'(0));
        tick();
        tick();
        check_bus("bus_mr");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
